pingpong_frame_scheduler: RTL and testbench

PINGPONG_FRAME_SCHEDULER -- requirements
Module: pingpong_frame_scheduler

---
 rtl/pingpong_frame_scheduler_if.sv | 35 +++
 rtl/pingpong_frame_scheduler.sv | 129 ++++++++++++
 tb/tb_pingpong_frame_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_frame_scheduler_if.sv
// pingpong_frame_scheduler_if: host strobe, raster geometry and all control
// outputs of the ping-pong frame scheduler, bundled for port connection.
// master = host/display side, slave = the scheduler itself.
interface pingpong_frame_scheduler_if;
  logic       CSDisplay;
  logic [9:0] AIPOut;
  logic [9:0] HBOut;
  logic [9:0] AILOut;
  logic [9:0] VBOut;
  logic [9:0] PxOut;
  logic [9:0] LineOut;
  logic       IncPx, ResetPx, IncLine, ResetLine;
  logic       WE0, WE1, RE0, RE1;
  logic       IncAddr0, IncAddr1, ResetAddr0, ResetAddr1;
  logic       SelBuf0, SelBuf1, SelBlank;
  logic       SyncHB, SyncVB;
  logic       Buf0Empty, Buf1Empty;
  logic       Overrun;

  modport master (
    output CSDisplay, AIPOut, HBOut, AILOut, VBOut,
    input  PxOut, LineOut, IncPx, ResetPx, IncLine, ResetLine,
    input  WE0, WE1, RE0, RE1, IncAddr0, IncAddr1, ResetAddr0, ResetAddr1,
    input  SelBuf0, SelBuf1, SelBlank, SyncHB, SyncVB,
    input  Buf0Empty, Buf1Empty, Overrun
  );

  modport slave (
    input  CSDisplay, AIPOut, HBOut, AILOut, VBOut,
    output PxOut, LineOut, IncPx, ResetPx, IncLine, ResetLine,
    output WE0, WE1, RE0, RE1, IncAddr0, IncAddr1, ResetAddr0, ResetAddr1,
    output SelBuf0, SelBuf1, SelBlank, SyncHB, SyncVB,
    output Buf0Empty, Buf1Empty, Overrun
  );
endinterface

// File: rtl/pingpong_frame_scheduler.sv
// pingpong_frame_scheduler: raster timing generator plus ping-pong frame
// buffer scheduling. One buffer fills from host writes while the other is
// displayed; the roles swap at a frame boundary once a complete frame is in.
// Optional macro DISP_FRAME_REPEAT_EN: when no new frame is ready at a frame
// boundary, replay the displayed frame instead of showing a blank frame.
module pingpong_frame_scheduler (
  input  logic                      clk,
  input  logic                      reset,
  pingpong_frame_scheduler_if.slave bus
);

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} fill_state_t;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} disp_state_t;

  logic [9:0]  px_reg, px_next;
  logic [9:0]  line_reg, line_next;
  logic        role_reg, role_next;    // 0: buffer 0 fills, buffer 1 displays
  fill_state_t fill_reg, fill_next;
  disp_state_t disp_reg, disp_next;
  logic [19:0] count_reg, count_next;  // words written into the fill buffer

  logic [10:0] line_len, frame_len;
  logic [19:0] frame_words;
  logic        last_px, last_line, boundary, active;
  logic        write_ok, final_word, swap, show_px, replay;

  // Geometry is sampled live; 11-bit sums avoid overflow of AIP+HB / AIL+VB.
  assign line_len    = {1'b0, bus.AIPOut} + {1'b0, bus.HBOut};
  assign frame_len   = {1'b0, bus.AILOut} + {1'b0, bus.VBOut};
  assign frame_words = {10'd0, bus.AIPOut} * {10'd0, bus.AILOut};

  assign last_px    = ({1'b0, px_reg} + 11'd1) >= line_len;
  assign last_line  = ({1'b0, line_reg} + 11'd1) >= frame_len;
  assign boundary   = last_px && last_line && !reset;
  assign active     = (px_reg < bus.AIPOut) && (line_reg < bus.AILOut);

  // An empty geometry (AIP or AIL zero) has zero words per frame and can
  // therefore never complete a frame.
  assign write_ok   = bus.CSDisplay && (fill_reg == FILLING) && !reset;
  assign final_word = write_ok && (frame_words != 20'd0) &&
                      ((count_reg + 20'd1) == frame_words);
  assign swap       = boundary && (fill_reg == FULL);
  assign show_px    = (disp_reg == SHOW) && active && !reset;

`ifdef DISP_FRAME_REPEAT_EN
  assign replay = boundary && (fill_reg != FULL) && (disp_reg == SHOW);
`else
  assign replay = 1'b0;
`endif

  // State register: raster counters, role bit, fill and display FSMs.
  always_ff @(posedge clk) begin
    if (reset) begin
      px_reg    <= '0;
      line_reg  <= '0;
      role_reg  <= 1'b0;
      fill_reg  <= FILLING;
      disp_reg  <= BLANK;
      count_reg <= '0;
    end else begin
      px_reg    <= px_next;
      line_reg  <= line_next;
      role_reg  <= role_next;
      fill_reg  <= fill_next;
      disp_reg  <= disp_next;
      count_reg <= count_next;
    end
  end

  // Next state: raster advance, fill progress, and the frame-boundary swap.
  always_comb begin
    px_next    = last_px ? 10'd0 : px_reg + 10'd1;
    line_next  = line_reg;
    if (last_px) begin
      line_next = last_line ? 10'd0 : line_reg + 10'd1;
    end
    role_next  = role_reg;
    fill_next  = fill_reg;
    disp_next  = disp_reg;
    count_next = count_reg;
    if (swap) begin
      // A FULL buffer never accepts a write, so a swap never races a write.
      role_next  = ~role_reg;
      fill_next  = FILLING;
      count_next = '0;
      disp_next  = SHOW;
    end else begin
      if (write_ok) begin
        count_next = count_reg + 20'd1;
        if (final_word) begin
          fill_next = FULL;
        end
      end
`ifndef DISP_FRAME_REPEAT_EN
      if (boundary) begin
        disp_next = BLANK;
      end
`endif
    end
  end

  // Outputs: combinational decodes of the registered state, forced to the
  // idle/reset pattern while reset is high.
  always_comb begin
    bus.PxOut      = reset ? 10'd0 : px_reg;
    bus.LineOut    = reset ? 10'd0 : line_reg;
    bus.IncPx      = !reset;
    bus.ResetPx    = reset || last_px;
    bus.IncLine    = !reset && last_px;
    bus.ResetLine  = reset || (last_px && last_line);
    bus.WE0        = write_ok && !role_reg;
    bus.WE1        = write_ok && role_reg;
    bus.RE0        = show_px && role_reg;
    bus.RE1        = show_px && !role_reg;
    bus.IncAddr0   = (write_ok && !role_reg) || (show_px && role_reg);
    bus.IncAddr1   = (write_ok && role_reg) || (show_px && !role_reg);
    bus.ResetAddr0 = reset || swap || (replay && role_reg);
    bus.ResetAddr1 = reset || swap || (replay && !role_reg);
    bus.SelBuf0    = show_px && role_reg;
    bus.SelBuf1    = show_px && !role_reg;
    bus.SelBlank   = !show_px;
    bus.SyncHB     = reset ? (bus.AIPOut == 10'd0) : (px_reg >= bus.AIPOut);
    bus.SyncVB     = reset ? (bus.AILOut == 10'd0) : (line_reg >= bus.AILOut);
    bus.Buf0Empty  = reset || (role_reg ? (disp_reg == BLANK) : (fill_reg == FILLING));
    bus.Buf1Empty  = reset || (role_reg ? (fill_reg == FILLING) : (disp_reg == BLANK));
    bus.Overrun    = bus.CSDisplay && (fill_reg == FULL) && !reset;
  end

endmodule

// File: tb/tb_pingpong_frame_scheduler.sv
// tb_pingpong_frame_scheduler: directed stimulus for the ping-pong frame
// scheduler, checked every cycle against a frame-level model (raster position
// from a cycle index, fill progress as a word count, display as a flag), plus
// hand-computed per-frame totals for the 4/2/3/1 geometry.
module tb_pingpong_frame_scheduler;
`ifdef DISP_FRAME_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  pingpong_frame_scheduler_if bus();

  pingpong_frame_scheduler dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miscompares = 0;

  // model: cycle index in frame, fill role, fill complete, display on
  int m_t = 0;
  bit m_role = 1'b0;
  bit m_full = 1'b0;
  bit m_show = 1'b0;
  int m_count = 0;

  // per-window totals taken from the DUT outputs
  int c_we0, c_we1, c_re0, c_re1, c_sb0, c_sb1, c_blank, c_ovr;
  int c_ra0, c_ra1, c_e0, c_e1, c_rl, c_cyc, rl_first, rl_last, rl_px, rl_line;

  task automatic clear_counts();
    c_we0 = 0; c_we1 = 0; c_re0 = 0; c_re1 = 0; c_sb0 = 0; c_sb1 = 0;
    c_blank = 0; c_ovr = 0; c_ra0 = 0; c_ra1 = 0; c_e0 = 0; c_e1 = 0;
    c_rl = 0; c_cyc = 0; rl_first = -1; rl_last = -1; rl_px = -1; rl_line = -1;
  endtask

  task automatic chk(input string name, input int actual, input int required);
    vecs++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d", name, actual, required);
    end
  endtask

  task automatic cyc(input bit cs);
    bus.CSDisplay = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc(1'b0);
  endtask

  // Per-cycle compare against the model, window totals, then model advance.
  always @(negedge clk) begin
    int aip, hb, ail, vb, ll, fl, px, ln, fw;
    bit lastp, lastl, bnd, act, wr, shw, swp, rep, d1;
    logic [39:0] exp_v, act_v, mask_v;
    aip = int'(bus.AIPOut); hb = int'(bus.HBOut);
    ail = int'(bus.AILOut); vb = int'(bus.VBOut);
    ll = aip + hb; fl = ail + vb;
    wr = 1'b0; swp = 1'b0; bnd = 1'b0;
    act_v = {bus.PxOut, bus.LineOut, bus.IncPx, bus.ResetPx, bus.IncLine,
             bus.ResetLine, bus.WE0, bus.WE1, bus.RE0, bus.RE1, bus.IncAddr0,
             bus.IncAddr1, bus.ResetAddr0, bus.ResetAddr1, bus.SelBuf0,
             bus.SelBuf1, bus.SelBlank, bus.SyncHB, bus.SyncVB, bus.Buf0Empty,
             bus.Buf1Empty, bus.Overrun};
    if (rst) begin
      exp_v = {10'd0, 10'd0, 4'b0101, 4'b0000, 2'b00, 2'b11, 3'b001,
               2'b00, 2'b11, 1'b0};
      mask_v = 40'hFF_FFFF_FFE7;
    end else begin
      px = m_t % ll;
      ln = m_t / ll;
      lastp = (px == ll - 1);
      lastl = (ln == fl - 1);
      bnd = lastp && lastl;
      act = (px < aip) && (ln < ail);
      wr  = bus.CSDisplay && !m_full;
      shw = m_show && act;
      swp = bnd && m_full;
      rep = REPEAT && bnd && !m_full && m_show;
      d1  = !m_role;
      exp_v[39:30] = 10'(px);
      exp_v[29:20] = 10'(ln);
      exp_v[19] = 1'b1;
      exp_v[18] = lastp;
      exp_v[17] = lastp;
      exp_v[16] = bnd;
      exp_v[15] = wr && !m_role;
      exp_v[14] = wr && m_role;
      exp_v[13] = shw && !d1;
      exp_v[12] = shw && d1;
      exp_v[11] = (wr && !m_role) || (shw && !d1);
      exp_v[10] = (wr && m_role) || (shw && d1);
      exp_v[9]  = swp || (rep && !d1);
      exp_v[8]  = swp || (rep && d1);
      exp_v[7]  = shw && !d1;
      exp_v[6]  = shw && d1;
      exp_v[5]  = !shw;
      exp_v[4]  = (px >= aip);
      exp_v[3]  = (ln >= ail);
      exp_v[2]  = m_role ? !m_show : !m_full;
      exp_v[1]  = m_role ? !m_full : !m_show;
      exp_v[0]  = bus.CSDisplay && m_full;
      mask_v = '1;
    end
    vecs++;
    if ((act_v & mask_v) !== (exp_v & mask_v)) begin
      miscompares++;
      $display("FAIL cycle_check t=%0d rst=%0b: got %h required %h",
               m_t, rst, act_v & mask_v, exp_v & mask_v);
    end

    c_we0 += int'(bus.WE0); c_we1 += int'(bus.WE1);
    c_re0 += int'(bus.RE0); c_re1 += int'(bus.RE1);
    c_sb0 += int'(bus.SelBuf0); c_sb1 += int'(bus.SelBuf1);
    c_blank += int'(bus.SelBlank); c_ovr += int'(bus.Overrun);
    c_ra0 += int'(bus.ResetAddr0); c_ra1 += int'(bus.ResetAddr1);
    c_e0 += int'(bus.Buf0Empty); c_e1 += int'(bus.Buf1Empty);
    if (bus.ResetLine && !rst) begin
      if (rl_first < 0) begin
        rl_first = c_cyc;
        rl_px = int'(bus.PxOut);
        rl_line = int'(bus.LineOut);
      end
      rl_last = c_cyc;
      c_rl++;
    end
    c_cyc++;

    if (rst) begin
      m_t = 0; m_role = 1'b0; m_full = 1'b0; m_show = 1'b0; m_count = 0;
    end else begin
      fw = aip * ail;
      if (wr) begin
        m_count++;
        if (fw > 0 && m_count == fw) m_full = 1'b1;
      end
      if (swp) begin
        m_role = !m_role; m_full = 1'b0; m_count = 0; m_show = 1'b1;
      end else if (bnd && !REPEAT) begin
        m_show = 1'b0;
      end
      m_t = (m_t + 1) % (ll * fl);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.CSDisplay = 1'b0;
    bus.AIPOut = 10'd4; bus.HBOut = 10'd2; bus.AILOut = 10'd3; bus.VBOut = 10'd1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("init_px", int'(bus.PxOut), 0);
    chk("init_selblank", int'(bus.SelBlank), 1);
    chk("init_resetaddr0", int'(bus.ResetAddr0), 1);
    chk("init_buf1empty", int'(bus.Buf1Empty), 1);
    @(posedge clk);
    #1;

    // Two idle frames: 24-cycle period, boundary at PxOut=5/LineOut=3.
    rst = 1'b0;
    clear_counts();
    run(48);
    chk("idle_rl_count", c_rl, 2);
    chk("idle_rl_first", rl_first, 23);
    chk("idle_rl_last", rl_last, 47);
    chk("idle_rl_px", rl_px, 5);
    chk("idle_rl_line", rl_line, 3);
    chk("idle_blank", c_blank, 48);
    chk("idle_e0", c_e0, 48);
    chk("idle_e1", c_e1, 48);

    // Fill buffer 0 with 12 words; swap at this frame's boundary.
    clear_counts();
    repeat (12) cyc(1'b1);
    run(12);
    chk("fill0_we0", c_we0, 12);
    chk("fill0_we1", c_we1, 0);
    chk("fill0_ovr", c_ovr, 0);
    chk("fill0_ra0", c_ra0, 1);

    // Display buffer 0 while filling buffer 1; 13th word overruns.
    clear_counts();
    repeat (13) cyc(1'b1);
    run(11);
    chk("show0_re0", c_re0, 12);
    chk("show0_sb0", c_sb0, 12);
    chk("show0_blank", c_blank, 12);
    chk("show0_e0", c_e0, 0);
    chk("fill1_we1", c_we1, 12);
    chk("fill1_we0", c_we0, 0);
    chk("fill1_ovr", c_ovr, 1);
    chk("fill1_e1", c_e1, 12);
    chk("fill1_ra1", c_ra1, 1);

    // Display buffer 1; nothing new at its boundary.
    clear_counts();
    run(24);
    chk("show1_re1", c_re1, 12);
    chk("show1_sb1", c_sb1, 12);
    chk("show1_re0", c_re0, 0);
    chk("show1_ra1", c_ra1, REPEAT ? 1 : 0);
    chk("show1_ra0", c_ra0, 0);

    // Blank or replay frame; final fill word lands on the boundary cycle.
    clear_counts();
    repeat (11) cyc(1'b1);
    while (m_t != 23) cyc(1'b0);
    cyc(1'b1);
    chk("late_we0", c_we0, 12);
    chk("late_ra0", c_ra0, 0);
    chk("nonew_re1", c_re1, REPEAT ? 12 : 0);
    chk("nonew_blank", c_blank, REPEAT ? 12 : 24);
    chk("nonew_e1", c_e1, REPEAT ? 0 : 24);
    chk("late_e0", c_e0, 24);

    // Buffer 0 is complete but waits a whole frame for the next boundary.
    clear_counts();
    run(24);
    chk("wait_re0", c_re0, 0);
    chk("wait_e0", c_e0, 0);
    chk("wait_ra0", c_ra0, 1);
    chk("wait_re1", c_re1, REPEAT ? 12 : 0);

    // Show buffer 0, then reset at PxOut=2/LineOut=1.
    clear_counts();
    while (m_t != 8) cyc(1'b0);
    chk("pre_rst_re0", c_re0, 6);
    chk("pre_rst_sb0", c_sb0, 6);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_px", int'(bus.PxOut), 0);
    chk("rst_line", int'(bus.LineOut), 0);
    chk("rst_selblank", int'(bus.SelBlank), 1);
    chk("rst_selbuf0", int'(bus.SelBuf0), 0);
    chk("rst_re0", int'(bus.RE0), 0);
    chk("rst_resetaddr0", int'(bus.ResetAddr0), 1);
    chk("rst_resetaddr1", int'(bus.ResetAddr1), 1);
    chk("rst_resetpx", int'(bus.ResetPx), 1);
    chk("rst_resetline", int'(bus.ResetLine), 1);
    chk("rst_incpx", int'(bus.IncPx), 0);
    chk("rst_buf0empty", int'(bus.Buf0Empty), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_px", int'(bus.PxOut), 0);
    chk("post_rst_line", int'(bus.LineOut), 0);
    chk("post_rst_selblank", int'(bus.SelBlank), 1);
    chk("post_rst_buf0empty", int'(bus.Buf0Empty), 1);
    chk("post_rst_incpx", int'(bus.IncPx), 1);
    @(posedge clk);
    #1;
    run(23);
    clear_counts();
    run(24);
    chk("after_rst_blank", c_blank, 24);
    chk("after_rst_re0", c_re0, 0);
    chk("after_rst_e0", c_e0, 24);
    chk("after_rst_e1", c_e1, 24);

    // AIP=0: writes accepted forever, never a complete frame, always blank.
    rst = 1'b1;
    bus.AIPOut = 10'd0;
    cyc(1'b0);
    cyc(1'b0);
    rst = 1'b0;
    clear_counts();
    repeat (20) cyc(1'b1);
    run(20);
    chk("zero_blank", c_blank, 40);
    chk("zero_ovr", c_ovr, 0);
    chk("zero_we0", c_we0, 20);
    chk("zero_re", c_re0 + c_re1, 0);
    chk("zero_e0", c_e0, 40);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
